fetch_align_buf: RTL and testbench
==================================

# fetch_align_buf

Two-line instruction-byte buffer between the fetch line interface and the decoder. It accepts 16-byte fetch lines and tracks a byte read pointer. It presents the decoder with a 16-byte window aligned so byte 0 is the next undecoded byte. The decoder retires a variable number of bytes (0–16) per cycle. Alignment uses the team's 32-byte byte-granular right rotator on the concatenated two-line store.

## Interface
- LINE_BYTES, 16, bytes per fetch line and per output window; fixed at 16 in this revision.
- PTR_W, 4, width of the in-line byte pointer, log2(LINE_BYTES).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fill_valid  in  1  fetch line present.
- fill_ready  out  1  buffer accepts line this cycle.
- fill_data  in  128  fetch line; byte k at bits [8k+7:8k].
- redirect  in  1  flush buffer, restart at new pointer.
- redirect_ptr  in  4  starting byte offset within next accepted line.
- out_valid  out  1  out_avail != 0.
- out_avail  out  5  valid bytes in window, 0..16.
- out_data  out  128  aligned window; bytes at index ≥ out_avail forced to 0.
- consume_valid  in  1  decoder retires bytes.
- consume_len  in  5  bytes retired, 0..16.

## Operation
- State: line0 (head), line1, v0, v1, ptr[3:0].
- avail_raw = (v0 ? 16−ptr : 0) + (v1 ? 16 : 0); out_avail = min(avail_raw, 16).
- out_data = low 128 bits of rotate_right_bytes({line1, line0}, {1'b0, ptr}), masked by out_avail.
- Effective consume: len_eff = consume_valid ? min(consume_len, out_avail) : 0. Over-length consume is clamped, never an error.
- sum = ptr + len_eff (5 bits).
  - sum ≥ 16: line0 retires. line1→line0, v0←v1, v1←0, ptr←sum−16.
  - sum < 16: ptr←sum.
- fill_ready = !(v0 && v1) && !redirect.
- Accepted fill goes to the lowest empty slot after the same-cycle retire:
  - !v0: fill→line0.
  - v0 && !v1 && retire: fill→line0.
  - v0 && !v1 && !retire: fill→line1.
  - v0 && v1 && retire: line1→line0, fill→line1.
  - Last case unreachable, since fill_ready=0; reserved.
- redirect (highest priority): v0←0, v1←0, ptr←redirect_ptr. Same-cycle consume and fill are ignored.
- Empty with ptr≠0 is legal. The first fill after a redirect starts at ptr.

## Timing
- Reset values: v0=v1=0, ptr=0, line0=line1=0.
  - Outputs after reset: out_valid=0, out_avail=0, out_data=0, fill_ready=1.
- out_* are combinational from registered state only; no input→output path except fill_ready←redirect.
- Fill latency: line accepted at edge N appears in out_data after edge N (visible cycle N+1).
- Consume takes effect at the edge; the new window is visible next cycle.
- Throughput: sustained 16 B/cycle when fill is back-to-back.
- Reset asserted mid-operation overrides redirect, fill and consume in that cycle.

## Structure
- Shared package `fetch_pkg`:
  - FETCH_LINE_BYTES=16, FETCH_PTR_W=4, FETCH_LEN_W=5.
  - typedef for the 128-bit fetch line.
- Single sub-module: shift_right_rotate (WIDTH=32, 8-bit lanes), instantiated once on {line1, line0}; only its low 16 bytes are used.
- Masking, pointer arithmetic and slot control live in the top module.

## Test plan
- Reset → out_avail=0, out_valid=0, fill_ready=1; fill line A (bytes 0x00..0x0F) → next cycle out_avail=16, out_data byte0=0x00, byte15=0x0F.
- Lines A then B (0x10..0x1F) loaded, consume 5 → out_avail=16, out_data byte0=0x05, byte11=0x10, byte15=0x14; fill_ready=0 before consume, 1 after line A retires.
- ptr=12 with lines A, B; consume 4 and fill C same cycle → A retires, B→line0, C→line1, ptr=0, window byte0=0x10.
- redirect with redirect_ptr=9 while both lines valid, consume_valid=1, fill_valid=1 → next cycle out_avail=0, fill_ready=1. Fill D (0x20..0x2F) → out_avail=7, byte0=0x29, bytes 7..15 zero.
- Only line A valid, ptr=10, consume_len=16 → clamped to 6; v0=0, ptr=0, out_avail=0.
- rst asserted in same cycle as fill and redirect → all state at reset values next cycle; fill is not stored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the fetch line payload type.
package fetch_pkg;

    localparam int unsigned FETCH_LINE_BYTES = 16;
    localparam int unsigned FETCH_PTR_W      = 4;
    localparam int unsigned FETCH_LEN_W      = 5;
    localparam int unsigned FETCH_LINE_W     = FETCH_LINE_BYTES * 8;

    typedef logic [FETCH_LINE_W-1:0] fetch_line_t;

endpackage

// File: rtl/shift_right_rotate.sv
// Lane-granular right rotator: output lane k is input lane (k + amt) mod WIDTH.
// OUT_LANES lets a caller keep only the low lanes of the rotated word.
module shift_right_rotate #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned OUT_LANES = WIDTH
) (
    input  logic [WIDTH*LANE_W-1:0]     data,
    input  logic [$clog2(WIDTH)-1:0]    amt,
    output logic [OUT_LANES*LANE_W-1:0] rot_c
);

    localparam int unsigned TOT_W = WIDTH * LANE_W;
    localparam int unsigned OUT_W = OUT_LANES * LANE_W;
    localparam int unsigned AMT_W = $clog2(WIDTH);
    localparam int unsigned LSH_W = $clog2(LANE_W);
    localparam int unsigned SH_W  = AMT_W + LSH_W;

    logic [2*TOT_W-1:0] dbl;
    logic [SH_W-1:0]    shamt;

    // Shifting the doubled word right by amt lanes leaves the rotation in the low half.
    always_comb begin
        dbl   = {data, data};
        shamt = {amt, LSH_W'(0)};
        rot_c = OUT_W'(dbl >> shamt);
    end

endmodule

// File: rtl/fetch_align_buf.sv
// Two-line fetch byte buffer presenting a 16-byte decoder window aligned to the
// next undecoded byte, with clamped variable-length consume and redirect flush.
module fetch_align_buf
    import fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fill_valid,
    output logic                    fill_ready,
    input  logic [FETCH_LINE_W-1:0] fill_data,
    input  logic                    redirect,
    input  logic [FETCH_PTR_W-1:0]  redirect_ptr,
    output logic                    out_valid,
    output logic [FETCH_LEN_W-1:0]  out_avail,
    output logic [FETCH_LINE_W-1:0] out_data,
    input  logic                    consume_valid,
    input  logic [FETCH_LEN_W-1:0]  consume_len
);

    localparam int unsigned RAW_W = FETCH_LEN_W + 1;

    fetch_line_t            line0, line1, line0_n, line1_n;
    logic                   v0, v1, v0_n, v1_n;
    logic [FETCH_PTR_W-1:0] ptr, ptr_n;

    logic [RAW_W-1:0]        avail_raw;
    logic [FETCH_LEN_W-1:0]  len_eff;
    logic [FETCH_LEN_W-1:0]  sum;
    logic                    retire;
    logic                    fill_acc;
    fetch_line_t             rot;

    shift_right_rotate #(
        .WIDTH     (2 * FETCH_LINE_BYTES),
        .LANE_W    (8),
        .OUT_LANES (FETCH_LINE_BYTES)
    ) u_rot (
        .data  ({line1, line0}),
        .amt   ({1'b0, ptr}),
        .rot_c (rot)
    );

    // Window size and byte masking, all from registered state.
    always_comb begin
        avail_raw = (v0 ? (RAW_W'(FETCH_LINE_BYTES) - RAW_W'(ptr)) : RAW_W'(0))
                  + (v1 ? RAW_W'(FETCH_LINE_BYTES) : RAW_W'(0));
        out_avail = (avail_raw > RAW_W'(FETCH_LINE_BYTES)) ? FETCH_LEN_W'(FETCH_LINE_BYTES)
                                                           : FETCH_LEN_W'(avail_raw);
        out_valid = (out_avail != FETCH_LEN_W'(0));
        out_data  = '0;
        for (int i = 0; i < int'(FETCH_LINE_BYTES); i++) begin
            if (FETCH_LEN_W'(i) < out_avail) begin
                out_data[8*i +: 8] = rot[8*i +: 8];
            end
        end
    end

    assign fill_ready = !(v0 && v1) && !redirect;

    // Pointer advance, head retirement and fill slot selection.
    always_comb begin
        line0_n  = line0;
        line1_n  = line1;
        v0_n     = v0;
        v1_n     = v1;
        ptr_n    = ptr;
        len_eff  = '0;
        if (consume_valid) begin
            len_eff = (consume_len > out_avail) ? out_avail : consume_len;
        end
        sum      = FETCH_LEN_W'(ptr) + len_eff;
        retire   = sum[FETCH_LEN_W-1];
        fill_acc = fill_valid && fill_ready;

        if (redirect) begin
            v0_n  = 1'b0;
            v1_n  = 1'b0;
            ptr_n = redirect_ptr;
        end else begin
            ptr_n = sum[FETCH_PTR_W-1:0];
            if (retire) begin
                line0_n = line1;
                v0_n    = v1;
                v1_n    = 1'b0;
            end
            // Fill lands in the lowest slot left empty after this cycle's retire.
            if (fill_acc) begin
                if (!v0_n) begin
                    line0_n = fill_data;
                    v0_n    = 1'b1;
                end else begin
                    line1_n = fill_data;
                    v1_n    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line0 <= '0;
            line1 <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            ptr   <= '0;
        end else begin
            line0 <= line0_n;
            line1 <= line1_n;
            v0    <= v0_n;
            v1    <= v1_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_fetch_align_buf.sv
// Scoreboard bench for fetch_align_buf: a byte-queue reference model predicts each
// cycle's outputs, a separate monitor compares them against the DUT.
module tb_fetch_align_buf;

    logic         clk;
    logic         rst;
    logic         fill_valid;
    logic         fill_ready;
    logic [127:0] fill_data;
    logic         redirect;
    logic [3:0]   redirect_ptr;
    logic         out_valid;
    logic [4:0]   out_avail;
    logic [127:0] out_data;
    logic         consume_valid;
    logic [4:0]   consume_len;

    fetch_align_buf dut (
        .clk           (clk),
        .rst           (rst),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_data     (fill_data),
        .redirect      (redirect),
        .redirect_ptr  (redirect_ptr),
        .out_valid     (out_valid),
        .out_avail     (out_avail),
        .out_data      (out_data),
        .consume_valid (consume_valid),
        .consume_len   (consume_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [4:0]   avail;
        logic [127:0] data;
        logic         ready;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: bytes of the held lines in order, line count, head offset.
    logic [7:0] mq[$];
    int         nlines = 0;
    int         hoff   = 0;

    function automatic int model_avail();
        int a;
        a = (nlines > 0) ? nlines * 16 - hoff : 0;
        return (a > 16) ? 16 : a;
    endfunction

    function automatic logic [127:0] mk_line(input int base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'(base + k);
        return l;
    endfunction

    function automatic logic [127:0] rnd_line();
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic step(input logic fv, input logic [127:0] fd, input logic cv,
                        input logic [4:0] cl, input logic rd, input logic [3:0] rp,
                        input logic rs);
        exp_t e;
        int   a, len;
        logic fr;
        a       = model_avail();
        fr      = (nlines < 2) && !rd;
        e.valid = (a != 0);
        e.avail = 5'(a);
        e.ready = fr;
        e.data  = '0;
        for (int i = 0; i < a; i++) e.data[8*i +: 8] = mq[hoff + i];
        exp_q.push_back(e);

        fill_valid    = fv;
        fill_data     = fd;
        consume_valid = cv;
        consume_len   = cl;
        redirect      = rd;
        redirect_ptr  = rp;
        rst           = rs;

        if (rs) begin
            mq.delete();
            nlines = 0;
            hoff   = 0;
        end else if (rd) begin
            mq.delete();
            nlines = 0;
            hoff   = int'(rp);
        end else begin
            len  = cv ? ((int'(cl) > a) ? a : int'(cl)) : 0;
            hoff = hoff + len;
            if (hoff >= 16 && nlines > 0) begin
                for (int k = 0; k < 16; k++) void'(mq.pop_front());
                nlines = nlines - 1;
                hoff   = hoff - 16;
            end
            if (fv && fr) begin
                for (int k = 0; k < 16; k++) mq.push_back(fd[8*k +: 8]);
                nlines = nlines + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid",  128'(out_valid),  128'(e.valid));
                chk("out_avail",  128'(out_avail),  128'(e.avail));
                chk("out_data",   out_data,         e.data);
                chk("fill_ready", 128'(fill_ready), 128'(e.ready));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] z;
        z             = '0;
        rst           = 1'b1;
        fill_valid    = 1'b0;
        fill_data     = '0;
        redirect      = 1'b0;
        redirect_ptr  = '0;
        consume_valid = 1'b0;
        consume_len   = '0;
        repeat (2) @(posedge clk);
        #1;

        // Directed walk through the documented scenarios.
        step(1, mk_line(8'h00), 0, 0,  0, 0, 0);
        step(1, mk_line(8'h10), 0, 0,  0, 0, 0);
        step(0, z,              1, 5,  0, 0, 0);
        step(0, z,              1, 7,  0, 0, 0);
        step(1, mk_line(8'h40), 1, 4,  0, 0, 0);
        step(1, mk_line(8'h40), 0, 0,  0, 0, 0);
        step(1, mk_line(8'h50), 1, 3,  1, 9, 0);
        step(1, mk_line(8'h20), 0, 0,  0, 0, 0);
        step(0, z,              1, 16, 0, 0, 0);
        step(1, mk_line(8'h60), 0, 0,  0, 0, 0);
        step(1, mk_line(8'h70), 1, 2,  1, 3, 1);
        step(0, z,              0, 0,  0, 0, 0);
        step(1, mk_line(8'h80), 1, 16, 0, 0, 0);
        step(1, mk_line(8'h90), 1, 16, 0, 0, 0);
        step(1, mk_line(8'hA0), 1, 16, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) < 7),
                 rnd_line(),
                 ($urandom_range(0, 9) < 7),
                 5'($urandom_range(0, 16)),
                 ($urandom_range(0, 39) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 199) == 0));
        end
        step(0, z, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
